// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller slice.
// Holds the default widths, the FSM state encoding and the word-align mask.
package cache_pkg;

  localparam int unsigned XLEN_DEF        = 32;
  localparam int unsigned BYTE_OFFSET_DEF = 2;

  // 2-bit controller state encoding
  localparam logic [1:0] S_IDLE_ENC    = 2'd0;
  localparam logic [1:0] S_RD_MEM_ENC  = 2'd1;
  localparam logic [1:0] S_RD_RESP_ENC = 2'd2;
  localparam logic [1:0] S_WR_MEM_ENC  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = S_IDLE_ENC,
    S_RD_MEM  = S_RD_MEM_ENC,
    S_RD_RESP = S_RD_RESP_ENC,
    S_WR_MEM  = S_WR_MEM_ENC
  } state_e;

  // Clears the byte-offset bits of an address at the default width
  localparam logic [XLEN_DEF-1:0] ADDR_MASK =
    ~XLEN_DEF'((XLEN_DEF'(1) << BYTE_OFFSET_DEF) - XLEN_DEF'(1));

  function automatic logic [XLEN_DEF-1:0] align_addr(input logic [XLEN_DEF-1:0] a);
    return a & ADDR_MASK;
  endfunction

endpackage

// File: rtl/cache_stat_counter.sv
// 32-bit wrapping event counter with synchronous clear and increment enable.
// Ports: i_clk clock, i_clr synchronous clear (priority), i_inc count enable,
//        o_count current count.
module cache_stat_counter (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] r_count;

  // Counter wraps naturally at 2^32
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller in front of a cache: answers read hits in the same
// cycle, fills the cache from memory on read misses, and performs
// write-through / write-allocate stores.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   cpu_*               CPU request/response (held stable until cpu_ready)
//   cache_addr/hit/data lookup port of the cache
//   update*             cache fill/refresh port
//   mem_*               backing memory request/response
//   stat_hits/misses    read hit / read miss counters (CACHE_CTRL_STATS_EN only)
// Build option: define CACHE_CTRL_STATS_EN to add the statistics counters.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned BYTE_OFFSET = BYTE_OFFSET_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  output logic            cpu_ready,
  output logic [XLEN-1:0] cpu_rdata,
  output logic [XLEN-1:0] cache_addr,
  input  logic            cache_hit,
  input  logic [XLEN-1:0] cache_data,
  output logic            update,
  output logic [XLEN-1:0] update_addr,
  output logic [XLEN-1:0] update_data,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_misses
`endif
);

  localparam logic [XLEN-1:0] L_ALIGN_MASK =
    ~((XLEN'(1) << BYTE_OFFSET) - XLEN'(1));

  state_e          r_state;
  state_e          w_next;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] w_addr_al;
  logic            w_lat_addr;
  logic            w_lat_wdata;
  logic            w_cap_rdata;

  assign cache_addr = cpu_addr;
  assign w_addr_al  = cpu_addr & L_ALIGN_MASK;

  // State and transaction latches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_lat_addr)  r_addr  <= w_addr_al;
      if (w_lat_wdata) r_wdata <= cpu_wdata;
      if (w_cap_rdata) r_rdata <= mem_rdata;
    end
  end

  // Next state and output decode; reset forces every strobe low
  always_comb begin
    w_next      = r_state;
    w_lat_addr  = 1'b0;
    w_lat_wdata = 1'b0;
    w_cap_rdata = 1'b0;
    cpu_ready   = 1'b0;
    cpu_rdata   = r_rdata;
    update      = 1'b0;
    update_addr = r_addr;
    update_data = r_wdata;
    mem_valid   = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = r_addr;
    mem_wdata   = r_wdata;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              w_lat_addr  = 1'b1;
              w_lat_wdata = 1'b1;
              w_next      = S_WR_MEM;
            end else if (cache_hit) begin
              cpu_ready = 1'b1;
              cpu_rdata = cache_data;
            end else begin
              w_lat_addr = 1'b1;
              w_next     = S_RD_MEM;
            end
          end
        end
        S_RD_MEM: begin
          mem_valid = 1'b1;
          if (mem_ready) begin
            update      = 1'b1;
            update_data = mem_rdata;
            w_cap_rdata = 1'b1;
            w_next      = S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          cpu_ready = 1'b1;
          cpu_rdata = r_rdata;
          w_next    = S_IDLE;
        end
        S_WR_MEM: begin
          mem_valid = 1'b1;
          mem_we    = 1'b1;
          if (mem_ready) begin
            update    = 1'b1;
            cpu_ready = 1'b1;
            w_next    = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic w_rd_hit;
  logic w_rd_miss;

  // Stores never count; a miss counts on the IDLE to RD_MEM transition
  assign w_rd_hit  = (r_state == S_IDLE) && cpu_req && !cpu_we && cache_hit;
  assign w_rd_miss = (r_state == S_IDLE) && cpu_req && !cpu_we && !cache_hit;

  cache_stat_counter u_hits (
    .i_clk   (clk),
    .i_clr   (rst),
    .i_inc   (w_rd_hit),
    .o_count (stat_hits)
  );

  cache_stat_counter u_misses (
    .i_clk   (clk),
    .i_clr   (rst),
    .i_inc   (w_rd_miss),
    .o_count (stat_misses)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with a behavioural cache and backing memory.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_data;
  logic        update;
  logic [31:0] update_addr, update_data;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rdata   (cpu_rdata),
    .cache_addr  (cache_addr),
    .cache_hit   (cache_hit),
    .cache_data  (cache_data),
    .update      (update),
    .update_addr (update_addr),
    .update_data (update_data),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  // Behavioural direct-mapped cache, cleared by reset (its rst_n = ~rst)
  logic [31:0] c_tag   [1024];
  logic [31:0] c_data  [1024];
  logic        c_valid [1024];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) c_valid[i] <= 1'b0;
    end else if (update) begin
      c_valid[update_addr[11:2]] <= 1'b1;
      c_tag[update_addr[11:2]]   <= update_addr;
      c_data[update_addr[11:2]]  <= update_data;
    end
  end

  always_comb begin
    cache_hit  = c_valid[cache_addr[11:2]] &&
                 (c_tag[cache_addr[11:2]] == (cache_addr & 32'hFFFF_FFFC));
    cache_data = c_data[cache_addr[11:2]];
  end

  // Backing memory with a programmable number of wait cycles
  logic [31:0] bmem [1024];
  int          mem_wait = 0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (rst || !mem_valid || mem_ready) m_cnt <= 0;
    else                                m_cnt <= m_cnt + 1;
  end

  assign mem_ready = mem_valid && (m_cnt == mem_wait);
  always_comb mem_rdata = bmem[mem_addr[11:2]];

  // Scoreboard
  typedef struct {
    logic        we;
    logic [31:0] rdata;
    int          start;
    int          lat;
    string       name;
  } cpu_exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } upd_exp_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  upd_exp_t upd_q[$];
  mem_exp_t mem_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mv_cnt  = 0;
  int rdy_cnt = 0;
  int upd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response
  always @(negedge clk) begin
    cpu_exp_t ce;
    upd_exp_t ue;
    mem_exp_t me;
    if (mem_valid) mv_cnt++;
    if (cpu_ready) begin
      rdy_cnt++;
      if (cpu_q.size() == 0) begin
        check32("unexpected_cpu_ready", 32'd1, 32'd0);
      end else begin
        ce = cpu_q.pop_front();
        check32({ce.name, "_latency"}, 32'(cyc - ce.start), 32'(ce.lat));
        if (!ce.we) check32({ce.name, "_rdata"}, cpu_rdata, ce.rdata);
      end
    end
    if (update) begin
      upd_cnt++;
      if (upd_q.size() == 0) begin
        check32("unexpected_update", 32'd1, 32'd0);
      end else begin
        ue = upd_q.pop_front();
        check32("update_addr", update_addr, ue.addr);
        check32("update_data", update_data, ue.data);
      end
    end
    if (mem_valid && mem_q.size() != 0) begin
      me = mem_q[0];
      check32("mem_addr", mem_addr, me.addr);
      check32("mem_we", 32'(mem_we), 32'(me.we));
      if (me.we) check32("mem_wdata", mem_wdata, me.wdata);
      if (mem_ready) void'(mem_q.pop_front());
    end else if (mem_valid && mem_ready) begin
      check32("unexpected_mem_xfer", 32'd1, 32'd0);
    end
  end

  task automatic push_cpu(input logic we, input logic [31:0] rdata, input int lat, input string name);
    cpu_exp_t e;
    e.we = we; e.rdata = rdata; e.start = cyc; e.lat = lat; e.name = name;
    cpu_q.push_back(e);
  endtask

  task automatic push_upd(input logic [31:0] addr, input logic [31:0] data);
    upd_exp_t e;
    e.addr = addr; e.data = data;
    upd_q.push_back(e);
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cpu_ready) return;
    end
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s_timeout: got no cpu_ready, expected one within 50 cycles", name);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input int lat, input string name);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    push_cpu(we, exp_rdata, lat, name);
    wait_ready(name);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int c0, mv0, rc0, uc0;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) bmem[i] = '0;
    bmem[32'h100 >> 2] = 32'hDEADBEEF;
    bmem[32'h104 >> 2] = 32'h1111_2222;
    bmem[32'h108 >> 2] = 32'h3333_4444;

    // Reset state
    repeat (2) @(posedge clk);
    cpu_req = 1'b1;
    @(negedge clk);
    check32("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check32("rst_update", 32'(update), 32'd0);
    check32("rst_mem_valid", 32'(mem_valid), 32'd0);
    check32("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);

    // 1: read miss with 3 wait cycles
    mem_wait = 3;
    push_mem(1'b0, 32'h100, 32'h0);
    push_upd(32'h100, 32'hDEADBEEF);
    issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 5, "t1_miss");

    // 2: four back-to-back hits, no memory traffic
    mv0 = mv_cnt;
    issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "t2_hit");
    c0 = cyc;
    for (int i = 0; i < 3; i++) issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "t2_hit");
    check32("t2_burst_cycles", 32'(cyc - c0), 32'd3);
    check32("t2_no_mem_valid", 32'(mv_cnt - mv0), 32'd0);

    // 3: misaligned store, then read back as a hit
    mem_wait = 1;
    push_mem(1'b1, 32'h200, 32'h12345678);
    push_upd(32'h200, 32'h12345678);
    issue(1'b1, 32'h203, 32'h12345678, 32'h0, 2, "t3_store");
    issue(1'b0, 32'h200, 32'h0, 32'h12345678, 0, "t3_rd_hit");

    // 4: cpu_addr changes while the miss is in flight
    do_reset();
    mem_wait = 4;
    push_mem(1'b0, 32'h100, 32'h0);
    push_upd(32'h100, 32'hDEADBEEF);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    push_cpu(1'b0, 32'hDEADBEEF, 6, "t4_addr_change");
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_addr = 32'h400;
    @(negedge clk);
    check32("t4_cache_addr", cache_addr, 32'h400);
    wait_ready("t4_addr_change");
    idle();

    // 5: reset while a store waits on memory
    mem_wait = 10;
    rc0 = rdy_cnt; uc0 = upd_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check32("t5_wr_mem_valid", 32'(mem_valid), 32'd1);
    check32("t5_wr_mem_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check32("t5_rst_mem_valid", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("t5_idle_mem_valid", 32'(mem_valid), 32'd0);
    check32("t5_idle_mem_we", 32'(mem_we), 32'd0);
    repeat (3) @(negedge clk);
    check32("t5_no_cpu_ready", 32'(rdy_cnt - rc0), 32'd0);
    check32("t5_no_update", 32'(upd_cnt - uc0), 32'd0);

    // 6: 3 misses, 5 hits, 2 stores
    do_reset();
`ifdef CACHE_CTRL_STATS_EN
    @(negedge clk);
    check32("t6_hits_after_rst", stat_hits, 32'd0);
    check32("t6_misses_after_rst", stat_misses, 32'd0);
`endif
    mem_wait = 0;
    push_mem(1'b0, 32'h100, 32'h0); push_upd(32'h100, 32'hDEADBEEF);
    issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, "t6_miss0");
    push_mem(1'b0, 32'h104, 32'h0); push_upd(32'h104, 32'h1111_2222);
    issue(1'b0, 32'h104, 32'h0, 32'h1111_2222, 2, "t6_miss1");
    push_mem(1'b0, 32'h108, 32'h0); push_upd(32'h108, 32'h3333_4444);
    issue(1'b0, 32'h108, 32'h0, 32'h3333_4444, 2, "t6_miss2");
    issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "t6_hit");
    issue(1'b0, 32'h104, 32'h0, 32'h1111_2222, 0, "t6_hit");
    issue(1'b0, 32'h108, 32'h0, 32'h3333_4444, 0, "t6_hit");
    issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "t6_hit");
    issue(1'b0, 32'h104, 32'h0, 32'h1111_2222, 0, "t6_hit");
    push_mem(1'b1, 32'h10C, 32'hAAAA5555); push_upd(32'h10C, 32'hAAAA5555);
    issue(1'b1, 32'h10C, 32'hAAAA5555, 32'h0, 1, "t6_store0");
    push_mem(1'b1, 32'h100, 32'h0BADF00D); push_upd(32'h100, 32'h0BADF00D);
    issue(1'b1, 32'h101, 32'h0BADF00D, 32'h0, 1, "t6_store1");
    idle();
    @(negedge clk);
`ifdef CACHE_CTRL_STATS_EN
    check32("t6_stat_hits", stat_hits, 32'd5);
    check32("t6_stat_misses", stat_misses, 32'd3);
`endif

    repeat (3) @(negedge clk);
    check32("end_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check32("end_upd_q_empty", 32'(upd_q.size()), 32'd0);
    check32("end_mem_q_empty", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
